// File: rtl/rf_1p_bwe.sv
// Single-port register file with per-lane write masking, selectable
// read-during-write behaviour, optional output register and a hardware
// clear sequencer that fills the array with INIT_VAL after reset/init.
module rf_1p_bwe #(
    parameter int unsigned WORD_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned LANE_WIDTH = 8,
    parameter int unsigned WR_THROUGH = 0,
    parameter int unsigned OUT_REG    = 0,
    parameter logic [WORD_WIDTH-1:0] INIT_VAL = '0,
    localparam int unsigned NUM_LANES = WORD_WIDTH / LANE_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cen_i,
    input  logic                  wen_i,
    input  logic [NUM_LANES-1:0]  bwen_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [WORD_WIDTH-1:0] data_i,
    input  logic                  init_i,
    output logic [WORD_WIDTH-1:0] data_o,
    output logic                  valid_o,
    output logic                  ready_o
);

    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
    localparam bit          WT_EN = (WR_THROUGH != 0);

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_t;

    state_t                  state;
    logic [ADDR_WIDTH-1:0]   clr_cnt;
    logic [WORD_WIDTH-1:0]   mem [DEPTH];
    logic [WORD_WIDTH-1:0]   stage1_q;
    logic                    stage1_vld_q;

    logic                    access_c;
    logic                    wr_c;
    logic                    rd_c;
    logic [WORD_WIDTH-1:0]   rd_word_c;
    logic [WORD_WIDTH-1:0]   merged_c;

    assign access_c  = (state == ST_READY) && !cen_i;
    assign wr_c      = access_c && !wen_i;
    assign rd_c      = access_c && wen_i;
    assign rd_word_c = mem[addr_i];

    // Merge enabled lanes of the write data over the currently stored word.
    always_comb begin
        merged_c = rd_word_c;
        for (int k = 0; k < int'(NUM_LANES); k++) begin
            if (!bwen_i[k]) begin
                merged_c[k*LANE_WIDTH +: LANE_WIDTH] = data_i[k*LANE_WIDTH +: LANE_WIDTH];
            end
        end
    end

    // Array write port: clear sequencer has priority, array itself is not reset.
    always_ff @(posedge clk) begin
        if (state == ST_CLEAR) begin
            mem[clr_cnt] <= INIT_VAL;
        end else if (wr_c) begin
            mem[addr_i] <= merged_c;
        end
    end

    // Clear/ready control and first output stage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_CLEAR;
            clr_cnt      <= '0;
            ready_o      <= 1'b0;
            stage1_q     <= '0;
            stage1_vld_q <= 1'b0;
        end else begin
            stage1_vld_q <= 1'b0;
            case (state)
                ST_CLEAR: begin
                    clr_cnt <= clr_cnt + ADDR_WIDTH'(1);
                    if (clr_cnt == '1) begin
                        state   <= ST_READY;
                        ready_o <= 1'b1;
                    end
                end
                ST_READY: begin
                    if (rd_c) begin
                        stage1_q     <= rd_word_c;
                        stage1_vld_q <= 1'b1;
                    end else if (wr_c && WT_EN) begin
                        stage1_q     <= merged_c;
                        stage1_vld_q <= 1'b1;
                    end
                    // A concurrent access completes on this same edge.
                    if (init_i) begin
                        state   <= ST_CLEAR;
                        clr_cnt <= '0;
                        ready_o <= 1'b0;
                    end
                end
                default: begin
                    state   <= ST_CLEAR;
                    clr_cnt <= '0;
                    ready_o <= 1'b0;
                end
            endcase
        end
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic [WORD_WIDTH-1:0] data_q;
            logic                  vld_q;

            // Second output stage: forwards only new data, holds otherwise.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    data_q <= '0;
                    vld_q  <= 1'b0;
                end else begin
                    vld_q <= stage1_vld_q;
                    if (stage1_vld_q) begin
                        data_q <= stage1_q;
                    end
                end
            end

            assign data_o  = data_q;
            assign valid_o = vld_q;
        end else begin : g_no_out_reg
            assign data_o  = stage1_q;
            assign valid_o = stage1_vld_q;
        end
    endgenerate

endmodule

// File: tb/tb_rf_1p_bwe.sv
// Directed bench for rf_1p_bwe: one instance with hold-on-write and no output
// register (a), one with write-through and an output register (b), shared inputs.
module tb_rf_1p_bwe;

    logic        clk;
    logic        rst;
    logic        cen;
    logic        wen;
    logic [3:0]  bwen;
    logic [3:0]  addr;
    logic [31:0] wdata;
    logic        init;

    logic [31:0] a_data;
    logic        a_vld;
    logic        a_rdy;
    logic [31:0] b_data;
    logic        b_vld;
    logic        b_rdy;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [31:0] IV = 32'hA5A5A5A5;

    rf_1p_bwe #(
        .WORD_WIDTH(32), .ADDR_WIDTH(4), .LANE_WIDTH(8),
        .WR_THROUGH(0), .OUT_REG(0), .INIT_VAL(IV)
    ) dut_a (
        .clk(clk), .rst(rst), .cen_i(cen), .wen_i(wen), .bwen_i(bwen),
        .addr_i(addr), .data_i(wdata), .init_i(init),
        .data_o(a_data), .valid_o(a_vld), .ready_o(a_rdy)
    );

    rf_1p_bwe #(
        .WORD_WIDTH(32), .ADDR_WIDTH(4), .LANE_WIDTH(8),
        .WR_THROUGH(1), .OUT_REG(1), .INIT_VAL(IV)
    ) dut_b (
        .clk(clk), .rst(rst), .cen_i(cen), .wen_i(wen), .bwen_i(bwen),
        .addr_i(addr), .data_i(wdata), .init_i(init),
        .data_o(b_data), .valid_o(b_vld), .ready_o(b_rdy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        cen;
        logic        wen;
        logic [3:0]  bwen;
        logic [3:0]  addr;
        logic [31:0] data;
        logic [31:0] a_data;
        logic        a_vld;
        logic [31:0] b_data;
        logic        b_vld;
    } vec_t;

    vec_t vecs[26];

    function automatic vec_t mk(input logic c, input logic w, input logic [3:0] be,
                                input logic [3:0] ad, input logic [31:0] d,
                                input logic [31:0] ea, input logic eav,
                                input logic [31:0] eb, input logic ebv);
        vec_t v;
        v.cen = c; v.wen = w; v.bwen = be; v.addr = ad; v.data = d;
        v.a_data = ea; v.a_vld = eav; v.b_data = eb; v.b_vld = ebv;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [31:0] ad, input logic av,
                           input logic [31:0] bd, input logic bv, input logic rdy);
        chk({tag, " a.data"},  a_data, ad);
        chk({tag, " a.valid"}, 32'(a_vld), 32'(av));
        chk({tag, " b.data"},  b_data, bd);
        chk({tag, " b.valid"}, 32'(b_vld), 32'(bv));
        chk({tag, " ready"},   32'({a_rdy, b_rdy}), rdy ? 32'd3 : 32'd0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic c, input logic w, input logic [3:0] be,
                         input logic [3:0] ad, input logic [31:0] d, input logic in);
        cen = c; wen = w; bwen = be; addr = ad; wdata = d; init = in;
    endtask

    task automatic idle();
        drive(1'b1, 1'b1, 4'hF, 4'h0, 32'h0, 1'b0);
    endtask

    // Expect ready low for 15 edges, high on the 16th.
    task automatic clear_window(input string tag);
        for (int j = 1; j <= 16; j++) begin
            step();
            chk($sformatf("%s ready edge %0d", tag, j), 32'({a_rdy, b_rdy}),
                (j == 16) ? 32'd3 : 32'd0);
        end
    endtask

    initial begin
        vecs[0]  = mk(0, 1, 4'hF, 4'd0,  32'h0,        IV,           1, IV,           0);
        vecs[1]  = mk(0, 1, 4'hF, 4'd15, 32'h0,        IV,           1, IV,           1);
        vecs[2]  = mk(0, 0, 4'h0, 4'd3,  32'h11223344, IV,           0, IV,           1);
        vecs[3]  = mk(0, 0, 4'hA, 4'd3,  32'hFFFFFFFF, IV,           0, 32'h11223344, 1);
        vecs[4]  = mk(0, 1, 4'hF, 4'd3,  32'h0,        32'h11FF33FF, 1, 32'h11FF33FF, 1);
        vecs[5]  = mk(1, 1, 4'hF, 4'd0,  32'h0,        32'h11FF33FF, 0, 32'h11FF33FF, 1);
        vecs[6]  = mk(1, 1, 4'hF, 4'd0,  32'h0,        32'h11FF33FF, 0, 32'h11FF33FF, 0);
        vecs[7]  = mk(0, 0, 4'h0, 4'd7,  32'hDEADBEEF, 32'h11FF33FF, 0, 32'h11FF33FF, 0);
        vecs[8]  = mk(0, 1, 4'hF, 4'd7,  32'h0,        32'hDEADBEEF, 1, 32'hDEADBEEF, 1);
        vecs[9]  = mk(0, 0, 4'hF, 4'd7,  32'h0,        32'hDEADBEEF, 0, 32'hDEADBEEF, 1);
        vecs[10] = mk(0, 1, 4'hF, 4'd7,  32'h0,        32'hDEADBEEF, 1, 32'hDEADBEEF, 1);
        vecs[11] = mk(1, 1, 4'hF, 4'd0,  32'h0,        32'hDEADBEEF, 0, 32'hDEADBEEF, 1);
        vecs[12] = mk(0, 0, 4'h0, 4'd0,  32'h00000001, 32'hDEADBEEF, 0, 32'hDEADBEEF, 0);
        vecs[13] = mk(0, 0, 4'h0, 4'd1,  32'h00000002, 32'hDEADBEEF, 0, 32'h00000001, 1);
        vecs[14] = mk(0, 0, 4'h0, 4'd2,  32'h00000003, 32'hDEADBEEF, 0, 32'h00000002, 1);
        vecs[15] = mk(0, 1, 4'hF, 4'd0,  32'h0,        32'h00000001, 1, 32'h00000003, 1);
        vecs[16] = mk(0, 1, 4'hF, 4'd1,  32'h0,        32'h00000002, 1, 32'h00000001, 1);
        vecs[17] = mk(0, 1, 4'hF, 4'd2,  32'h0,        32'h00000003, 1, 32'h00000002, 1);
        vecs[18] = mk(1, 1, 4'hF, 4'd0,  32'h0,        32'h00000003, 0, 32'h00000003, 1);
        vecs[19] = mk(1, 1, 4'hF, 4'd0,  32'h0,        32'h00000003, 0, 32'h00000003, 0);
        vecs[20] = mk(0, 0, 4'h0, 4'd9,  32'hCAFEF00D, 32'h00000003, 0, 32'h00000003, 0);
        vecs[21] = mk(0, 1, 4'hF, 4'd9,  32'h0,        32'hCAFEF00D, 1, 32'hCAFEF00D, 1);
        vecs[22] = mk(1, 1, 4'hF, 4'd0,  32'h0,        32'hCAFEF00D, 0, 32'hCAFEF00D, 1);
        vecs[23] = mk(0, 0, 4'h7, 4'd9,  32'h12345678, 32'hCAFEF00D, 0, 32'hCAFEF00D, 0);
        vecs[24] = mk(0, 1, 4'hF, 4'd9,  32'h0,        32'h12FEF00D, 1, 32'h12FEF00D, 1);
        vecs[25] = mk(1, 1, 4'hF, 4'd0,  32'h0,        32'h12FEF00D, 0, 32'h12FEF00D, 1);

        // Reset state
        rst = 1'b1;
        idle();
        step();
        step();
        chk_out("reset", 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);

        // Power-up clear: 16 cycles of ready low
        rst = 1'b0;
        clear_window("init clear");

        // Every entry holds INIT_VAL; b lags by one cycle
        for (int i = 0; i < 16; i++) begin
            drive(1'b0, 1'b1, 4'hF, 4'(i), 32'h0, 1'b0);
            step();
            chk_out($sformatf("initval rd %0d", i), IV, 1'b1,
                    (i == 0) ? 32'h0 : IV, (i == 0) ? 1'b0 : 1'b1, 1'b1);
        end
        idle();
        step();
        chk_out("initval drain", IV, 1'b0, IV, 1'b1, 1'b1);

        // Table-driven access vectors
        for (int i = 0; i < 26; i++) begin
            drive(vecs[i].cen, vecs[i].wen, vecs[i].bwen, vecs[i].addr, vecs[i].data, 1'b0);
            step();
            chk_out($sformatf("vec %0d", i), vecs[i].a_data, vecs[i].a_vld,
                    vecs[i].b_data, vecs[i].b_vld, 1'b1);
        end

        // init_i after writing addr 5, with a read issued alongside the pulse
        drive(1'b0, 1'b0, 4'h0, 4'd5, 32'h12345678, 1'b0);
        step();
        chk_out("init wr5", 32'h12FEF00D, 1'b0, 32'h12FEF00D, 1'b0, 1'b1);
        drive(1'b0, 1'b1, 4'hF, 4'd5, 32'h0, 1'b1);
        step();
        chk_out("init rd5", 32'h12345678, 1'b1, 32'h12345678, 1'b1, 1'b0);
        // Writes during the clear window must be ignored
        drive(1'b0, 1'b0, 4'h0, 4'd5, 32'h0, 1'b0);
        for (int j = 1; j <= 16; j++) begin
            step();
            chk_out($sformatf("clear2 edge %0d", j), 32'h12345678, 1'b0,
                    32'h12345678, (j == 1) ? 1'b1 : 1'b0, (j == 16) ? 1'b1 : 1'b0);
        end
        drive(1'b0, 1'b1, 4'hF, 4'd5, 32'h0, 1'b0);
        step();
        chk_out("post-init rd5", IV, 1'b1, 32'h12345678, 1'b0, 1'b1);
        idle();
        step();
        chk_out("post-init drain", IV, 1'b0, IV, 1'b1, 1'b1);

        // Reset at clear-counter value 9 restarts a full clear
        drive(1'b1, 1'b1, 4'hF, 4'd0, 32'h0, 1'b1);
        step();
        chk("init idle ready", 32'({a_rdy, b_rdy}), 32'd0);
        idle();
        for (int j = 0; j < 9; j++) step();
        rst = 1'b1;
        #1;
        chk_out("mid-clear reset", 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
        step();
        rst = 1'b0;
        clear_window("restart clear");

        drive(1'b0, 1'b1, 4'hF, 4'd5, 32'h0, 1'b0);
        step();
        chk_out("final rd5", IV, 1'b1, 32'h0, 1'b0, 1'b1);
        idle();
        step();
        chk_out("final drain", IV, 1'b0, IV, 1'b1, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
